axil_slave_regfile: RTL and testbench
=====================================

Name: axil_slave_regfile

Overview:
- Synthesizable AXI4-Lite slave that terminates the traffic generated by the team's AXI-Lite master agents and DUT masters.
- Implements a bank of NUM_REGS read/write registers with byte strobes and registered responses.
- Out-of-range addresses receive an error response.
- The full register contents are exported as a flat bus so surrounding logic in chip can consume them.

Parameters:
- ADDR_WIDTH, 12, width of AWADDR/ARADDR
- DATA_WIDTH, 32, data width; 32 or 64 only
- NUM_REGS, 16, number of registers; power of two, 2..256

Ports:
- aclk  in  1  single clock; all logic rising-edge
- aresetn  in  1  reset, asynchronous assert, active-low
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awprot  in  3  ignored
- s_axil_awvalid  in  1  write address valid
- s_axil_awready  out  1  write address ready
- s_axil_wdata  in  DATA_WIDTH  write data
- s_axil_wstrb  in  DATA_WIDTH/8  byte strobes
- s_axil_wvalid  in  1  write data valid
- s_axil_wready  out  1  write data ready
- s_axil_bresp  out  2  write response
- s_axil_bvalid  out  1  write response valid
- s_axil_bready  in  1  write response ready
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_arprot  in  3  ignored
- s_axil_arvalid  in  1  read address valid
- s_axil_arready  out  1  read address ready
- s_axil_rdata  out  DATA_WIDTH  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid  out  1  read response valid
- s_axil_rready  in  1  read response ready
- reg_out  out  NUM_REGS*DATA_WIDTH  register contents; register i at [i*DATA_WIDTH +: DATA_WIDTH]
- wr_pulse  out  NUM_REGS  one-cycle strobe; bit i set on the cycle a write commits to register i

Behaviour:
- Reset:
  - aresetn is asynchronous and active-low, synchronous deassert assumed upstream.
  - Reset clears: all registers to 0, bvalid, rvalid, wr_pulse, rdata to 0, bresp/rresp to 2'b00, and the aw_held/w_held flags.
  - awready, wready and arready are forced 0 while aresetn=0.
  - Reset mid-transaction discards all captured AW/W/AR state; no response is issued for it.
- Address decode:
  - ADDR_LSB = log2(DATA_WIDTH/8); index = addr[ADDR_LSB +: log2(NUM_REGS)].
  - Address bits below ADDR_LSB are ignored (unaligned accesses are treated as aligned).
  - The address is in range iff addr < NUM_REGS*(DATA_WIDTH/8).
- Write channel:
  - AW and W are accepted independently, in either order.
  - awready = aresetn & !aw_held & !bvalid; wready = aresetn & !w_held & !bvalid.
  - Each handshake latches its payload into a holding register and sets its held flag.
  - On the first edge where both held flags are set:
    - In range: each byte with wstrb=1 is updated; wr_pulse[index] pulses for exactly one cycle, even when wstrb=0.
    - Out of range: no register is modified and no pulse is issued.
    - bvalid rises with bresp = 2'b00 (OKAY) or 2'b10 (SLVERR); both held flags clear.
  - Latency: AW and W handshaking on the same edge N gives bvalid at edge N+1.
  - bvalid/bresp hold until bready; new AW/W are stalled while bvalid=1, so at most one write is outstanding.
- Read channel:
  - arready = aresetn & !rvalid.
  - On an AR handshake at edge N, rdata/rresp/rvalid are registered at edge N.
  - In range: rdata = reg[index], rresp = OKAY. Out of range: rdata = 0, rresp = SLVERR.
  - rdata/rresp hold stable until rready; rvalid falls on the edge where rready=1.
  - Maximum throughput is one read per 2 cycles.
- Simultaneous events:
  - A read sampled on the same edge as a write commit to the same register returns the old value.
  - The read and write paths are fully independent; neither stalls the other.
  - The internal write path has priority over nothing else; registers have no other writer.

Optional Feature:
- Macro: AXIL_SLV_DECERR_EN.
- Defined: out-of-range reads and writes respond DECERR (2'b11).
- Undefined: out-of-range accesses respond SLVERR (2'b10).
- All other behaviour is identical in both builds.

Test Plan:
- Write 0xDEADBEEF to 0x008 with wstrb=4'hF, AW and W in the same cycle -> bvalid one cycle later, bresp=00, reg_out word 2 = 0xDEADBEEF, wr_pulse[2] high for 1 cycle; read 0x008 -> rdata=0xDEADBEEF, rresp=00.
- W issued 3 cycles before AW (addr 0x00C, data 0x12345678, wstrb=4'b0101) on a reset-cleared register -> wready low after W is captured, single commit, word 3 = 0x00340078.
- Write to 0x040 (NUM_REGS=16) -> bresp=10 (11 with AXIL_SLV_DECERR_EN), no reg_out change, wr_pulse=0; read 0x040 -> rdata=0, same resp.
- Hold bready=0 for 5 cycles after a write -> bvalid/bresp stable, awready=wready=0 throughout; second write accepted only after B handshake.
- Hold rready=0 with rvalid=1 while writing the same register -> rdata stays at old value, arready=0 until R handshake.
- Assert aresetn=0 with AW captured and W pending -> all outputs reset immediately; after release, W alone produces no response; full write then reads back correctly.

Source files
------------

// File: rtl/axil_slave_regfile.sv
// axil_slave_regfile: AXI4-Lite slave with a bank of NUM_REGS byte-strobed
// read/write registers, registered B/R responses and a flat export of every
// register. AW and W are captured independently into holding registers and
// commit together one edge after both are held. Only one write can be
// outstanding at a time. Reads return the value held before any commit on
// the same edge.
//
// Build option: define AXIL_SLV_DECERR_EN to answer out-of-range accesses
// with DECERR (2'b11) instead of SLVERR (2'b10).
module axil_slave_regfile #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic [2:0]                     s_axil_awprot,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic [2:0]                     s_axil_arprot,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = $clog2(NUM_REGS);
  // One extra bit so the byte span of the bank always fits the compare.
  localparam logic [ADDR_WIDTH:0] RANGE_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS * STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] RESP_ERR = 2'b11;
`else
  localparam logic [1:0] RESP_ERR = 2'b10;
`endif

  // Protection bits carry no meaning for this slave.
  logic unused_prot;
  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_held_q, aw_held_d;
  logic [IDX_WIDTH-1:0]  aw_idx_q, aw_idx_d;
  logic                  aw_ok_q, aw_ok_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs;
  logic aw_in_range, ar_in_range;
  logic [IDX_WIDTH-1:0] ar_idx;

  assign s_axil_awready = aresetn & ~aw_held_q & ~bvalid_q;
  assign s_axil_wready  = aresetn & ~w_held_q & ~bvalid_q;
  assign s_axil_arready = aresetn & ~rvalid_q;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;

  assign aw_in_range = {1'b0, s_axil_awaddr} < RANGE_LIMIT;
  assign ar_in_range = {1'b0, s_axil_araddr} < RANGE_LIMIT;
  assign ar_idx      = s_axil_araddr[ADDR_LSB +: IDX_WIDTH];

  // Write path: capture AW/W, commit once both are held, then hold B until bready.
  always_comb begin
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    aw_ok_d    = aw_ok_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axil_awaddr[ADDR_LSB +: IDX_WIDTH];
      aw_ok_d   = aw_in_range;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end

    // Both held implies bvalid is low, so commit and B handshake never overlap.
    if (aw_held_q && w_held_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (aw_ok_q) begin
        bresp_d              = RESP_OKAY;
        wr_pulse_d[aw_idx_q] = 1'b1;
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (wstrb_q[b]) regs_d[aw_idx_q][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end else begin
        bresp_d = RESP_ERR;
      end
    end else if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Read path: register the response on the AR handshake, hold it until rready.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (ar_in_range) begin
        rdata_d = regs_q[ar_idx];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_ERR;
      end
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; reset drops any half-captured transaction silently.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      regs_q     <= '{default: '0};
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      aw_ok_q    <= 1'b0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      regs_q     <= regs_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      aw_ok_q    <= aw_ok_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign wr_pulse      = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Self-checking bench for axil_slave_regfile (default parameters).
// Expected values come from a plain array model of the register bank.
module tb_axil_slave_regfile;

`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] ERR = 2'b11;
`else
  localparam logic [1:0] ERR = 2'b10;
`endif

  logic         aclk = 1'b0;
  logic         aresetn = 1'b1;
  logic [11:0]  s_axil_awaddr = '0;
  logic [2:0]   s_axil_awprot = '0;
  logic         s_axil_awvalid = 1'b0;
  logic         s_axil_awready;
  logic [31:0]  s_axil_wdata = '0;
  logic [3:0]   s_axil_wstrb = '0;
  logic         s_axil_wvalid = 1'b0;
  logic         s_axil_wready;
  logic [1:0]   s_axil_bresp;
  logic         s_axil_bvalid;
  logic         s_axil_bready = 1'b0;
  logic [11:0]  s_axil_araddr = '0;
  logic [2:0]   s_axil_arprot = '0;
  logic         s_axil_arvalid = 1'b0;
  logic         s_axil_arready;
  logic [31:0]  s_axil_rdata;
  logic [1:0]   s_axil_rresp;
  logic         s_axil_rvalid;
  logic         s_axil_rready = 1'b0;
  logic [511:0] reg_out;
  logic [15:0]  wr_pulse;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] model [16];

  axil_slave_regfile dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit in_range(input logic [11:0] addr);
    return addr < 12'd64;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [11:0] addr);
    return in_range(addr) ? 2'b00 : ERR;
  endfunction

  function automatic void model_write(input logic [11:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    int idx;
    if (!in_range(addr)) return;
    idx = addr / 4;
    for (int b = 0; b < 4; b++)
      if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
  endfunction

  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endfunction

  // ---------------- bus helpers (no checking) ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [15:0] pulse, output bit to);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int cnt = 0;
    to = 0; resp = 'x; pulse = 'x;
    s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
    s_axil_wdata = data; s_axil_wstrb = strb; s_axil_wvalid = 1'b1;
    while (!(aw_done && w_done)) begin
      hs_aw = s_axil_awvalid && s_axil_awready;
      hs_w  = s_axil_wvalid && s_axil_wready;
      tick();
      if (hs_aw) begin aw_done = 1; s_axil_awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1;  s_axil_wvalid = 1'b0;  end
      cnt++;
      if (cnt > 50) begin to = 1; s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; return; end
    end
    cnt = 0;
    while (!s_axil_bvalid) begin
      tick(); cnt++;
      if (cnt > 50) begin to = 1; return; end
    end
    resp = s_axil_bresp; pulse = wr_pulse;
    s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit to);
    bit hs;
    int cnt = 0;
    to = 0; data = 'x; resp = 'x;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    forever begin
      hs = s_axil_arvalid && s_axil_arready;
      tick(); cnt++;
      if (hs) break;
      if (cnt > 50) begin to = 1; s_axil_arvalid = 1'b0; return; end
    end
    s_axil_arvalid = 1'b0;
    if (!s_axil_rvalid) begin to = 1; return; end
    data = s_axil_rdata; resp = s_axil_rresp;
    s_axil_rready = 1'b1; tick(); s_axil_rready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    model_clear();
    repeat (3) tick();
    n_checks++; if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b000) begin n_fail++;
      $display("FAIL reset_ready: got %b expected 000", {s_axil_awready, s_axil_wready, s_axil_arready}); end
    n_checks++; if ({s_axil_bvalid, s_axil_rvalid, s_axil_bresp, s_axil_rresp} !== 6'b0) begin n_fail++;
      $display("FAIL reset_resp: got %b expected 0", {s_axil_bvalid, s_axil_rvalid, s_axil_bresp, s_axil_rresp}); end
    n_checks++; if (reg_out !== 512'b0 || wr_pulse !== 16'h0 || s_axil_rdata !== 32'h0) begin n_fail++;
      $display("FAIL reset_regs: got wr_pulse=%h rdata=%h (reg_out nonzero=%b) expected 0", wr_pulse, s_axil_rdata, |reg_out); end
    aresetn = 1'b1;
    tick();
    n_checks++; if ({s_axil_awready, s_axil_wready, s_axil_arready} !== 3'b111) begin n_fail++;
      $display("FAIL post_reset_ready: got %b expected 111", {s_axil_awready, s_axil_wready, s_axil_arready}); end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] r; bit to;
    s_axil_awaddr = 12'h008; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'hDEADBEEF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n_checks++; if (s_axil_bvalid !== 1'b0) begin n_fail++;
      $display("FAIL basic_bvalid_early: got %b expected 0", s_axil_bvalid); end
    tick();
    model_write(12'h008, 32'hDEADBEEF, 4'hF);
    n_checks++; if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00) begin n_fail++;
      $display("FAIL basic_b: got bvalid=%b bresp=%b expected 1/00", s_axil_bvalid, s_axil_bresp); end
    n_checks++; if (reg_out[2*32 +: 32] !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL basic_word2: got %h expected deadbeef", reg_out[2*32 +: 32]); end
    n_checks++; if (wr_pulse !== 16'h0004) begin n_fail++;
      $display("FAIL basic_pulse: got %h expected 0004", wr_pulse); end
    s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0;
    n_checks++; if (wr_pulse !== 16'h0 || s_axil_bvalid !== 1'b0) begin n_fail++;
      $display("FAIL basic_pulse_width: got pulse=%h bvalid=%b expected 0/0", wr_pulse, s_axil_bvalid); end
    axi_read(12'h008, d, r, to);
    n_checks++; if (to !== 1'b0 || d !== 32'hDEADBEEF || r !== 2'b00) begin n_fail++;
      $display("FAIL basic_read: got to=%b rdata=%h rresp=%b expected 0/deadbeef/00", to, d, r); end
  endtask

  task automatic test_w_before_aw();
    s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'b0101; s_axil_wvalid = 1'b1;
    tick();
    s_axil_wvalid = 1'b0;
    n_checks++; if (s_axil_wready !== 1'b0) begin n_fail++;
      $display("FAIL wfirst_wready: got %b expected 0", s_axil_wready); end
    repeat (2) begin
      tick();
      n_checks++; if (s_axil_bvalid !== 1'b0) begin n_fail++;
        $display("FAIL wfirst_no_b: got bvalid=%b expected 0", s_axil_bvalid); end
    end
    s_axil_awaddr = 12'h00C; s_axil_awvalid = 1'b1;
    n_checks++; if (s_axil_awready !== 1'b1) begin n_fail++;
      $display("FAIL wfirst_awready: got %b expected 1", s_axil_awready); end
    tick();
    s_axil_awvalid = 1'b0;
    tick();
    model_write(12'h00C, 32'h12345678, 4'b0101);
    n_checks++; if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00 || wr_pulse !== 16'h0008) begin n_fail++;
      $display("FAIL wfirst_b: got bvalid=%b bresp=%b pulse=%h expected 1/00/0008", s_axil_bvalid, s_axil_bresp, wr_pulse); end
    n_checks++; if (reg_out[3*32 +: 32] !== 32'h00340078) begin n_fail++;
      $display("FAIL wfirst_word3: got %h expected 00340078", reg_out[3*32 +: 32]); end
    s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0;
    tick();
    n_checks++; if (s_axil_bvalid !== 1'b0 || reg_out !== model_flat()) begin n_fail++;
      $display("FAIL wfirst_single_commit: got bvalid=%b word3=%h expected 0/%h", s_axil_bvalid, reg_out[3*32 +: 32], model[3]); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; logic [15:0] p; bit to;
    axi_write(12'h040, 32'hCAFEF00D, 4'hF, r, p, to);
    n_checks++; if (to !== 1'b0 || r !== ERR || p !== 16'h0) begin n_fail++;
      $display("FAIL oor_write: got to=%b bresp=%b pulse=%h expected 0/%b/0000", to, r, p, ERR); end
    n_checks++; if (reg_out !== model_flat()) begin n_fail++;
      $display("FAIL oor_regs: reg_out changed by out-of-range write"); end
    axi_read(12'h040, d, r, to);
    n_checks++; if (to !== 1'b0 || d !== 32'h0 || r !== ERR) begin n_fail++;
      $display("FAIL oor_read: got to=%b rdata=%h rresp=%b expected 0/0/%b", to, d, r, ERR); end
    axi_write(12'h03F, 32'h0BADCAFE, 4'hF, r, p, to);
    model_write(12'h03F, 32'h0BADCAFE, 4'hF);
    n_checks++; if (to !== 1'b0 || r !== 2'b00 || p !== 16'h8000 || reg_out !== model_flat()) begin n_fail++;
      $display("FAIL last_byte_write: got to=%b bresp=%b pulse=%h word15=%h", to, r, p, reg_out[15*32 +: 32]); end
    axi_read(12'h00B, d, r, to);
    n_checks++; if (to !== 1'b0 || d !== model[2] || r !== 2'b00) begin n_fail++;
      $display("FAIL unaligned_read: got rdata=%h rresp=%b expected %h/00", d, r, model[2]); end
  endtask

  task automatic test_bready_stall();
    logic [1:0] r; logic [15:0] p; bit to;
    s_axil_awaddr = 12'h010; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h11223344; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    tick();
    model_write(12'h010, 32'h11223344, 4'hF);
    s_axil_awaddr = 12'h024; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h55667788; s_axil_wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00 || s_axil_awready !== 1'b0 || s_axil_wready !== 1'b0) begin
        n_fail++;
        $display("FAIL bstall_cycle%0d: got bvalid=%b bresp=%b awready=%b wready=%b expected 1/00/0/0",
                 i, s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready); end
      tick();
    end
    n_checks++; if (reg_out !== model_flat()) begin n_fail++;
      $display("FAIL bstall_no_second: got word9=%h word4=%h expected %h/%h", reg_out[9*32 +: 32], reg_out[4*32 +: 32], model[9], model[4]); end
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0;
    n_checks++; if (s_axil_bvalid !== 1'b0 || s_axil_awready !== 1'b1) begin n_fail++;
      $display("FAIL bstall_release: got bvalid=%b awready=%b expected 0/1", s_axil_bvalid, s_axil_awready); end
    axi_write(12'h024, 32'h55667788, 4'hF, r, p, to);
    model_write(12'h024, 32'h55667788, 4'hF);
    n_checks++; if (to !== 1'b0 || r !== 2'b00 || p !== 16'h0200 || reg_out !== model_flat()) begin n_fail++;
      $display("FAIL bstall_second: got to=%b bresp=%b pulse=%h word9=%h", to, r, p, reg_out[9*32 +: 32]); end
  endtask

  task automatic test_read_stall();
    logic [31:0] d; logic [1:0] r; logic [15:0] p; bit to;
    axi_write(12'h014, 32'hAAAA5555, 4'hF, r, p, to);
    model_write(12'h014, 32'hAAAA5555, 4'hF);
    s_axil_araddr = 12'h014; s_axil_arvalid = 1'b1;
    tick();
    s_axil_arvalid = 1'b0;
    n_checks++; if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'hAAAA5555) begin n_fail++;
      $display("FAIL rstall_first: got rvalid=%b rdata=%h expected 1/aaaa5555", s_axil_rvalid, s_axil_rdata); end
    axi_write(12'h014, 32'h0F0F0F0F, 4'hF, r, p, to);
    model_write(12'h014, 32'h0F0F0F0F, 4'hF);
    n_checks++; if (to !== 1'b0 || reg_out !== model_flat()) begin n_fail++;
      $display("FAIL rstall_write: got to=%b word5=%h expected 0/0f0f0f0f", to, reg_out[5*32 +: 32]); end
    n_checks++; if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'hAAAA5555 || s_axil_arready !== 1'b0) begin n_fail++;
      $display("FAIL rstall_hold: got rvalid=%b rdata=%h arready=%b expected 1/aaaa5555/0", s_axil_rvalid, s_axil_rdata, s_axil_arready); end
    s_axil_rready = 1'b1; tick(); s_axil_rready = 1'b0;
    n_checks++; if (s_axil_rvalid !== 1'b0 || s_axil_arready !== 1'b1) begin n_fail++;
      $display("FAIL rstall_release: got rvalid=%b arready=%b expected 0/1", s_axil_rvalid, s_axil_arready); end
    axi_read(12'h014, d, r, to);
    n_checks++; if (to !== 1'b0 || d !== 32'h0F0F0F0F || r !== 2'b00) begin n_fail++;
      $display("FAIL rstall_reread: got rdata=%h rresp=%b expected 0f0f0f0f/00", d, r); end
  endtask

  task automatic test_same_edge();
    logic [31:0] old_v;
    old_v = model[6];
    s_axil_awaddr = 12'h018; s_axil_awvalid = 1'b1;
    s_axil_wdata = ~old_v; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    s_axil_araddr = 12'h018; s_axil_arvalid = 1'b1;
    tick();
    s_axil_arvalid = 1'b0;
    model_write(12'h018, ~old_v, 4'hF);
    n_checks++; if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== old_v) begin n_fail++;
      $display("FAIL same_edge_read: got rvalid=%b rdata=%h expected 1/%h", s_axil_rvalid, s_axil_rdata, old_v); end
    n_checks++; if (s_axil_bvalid !== 1'b1 || reg_out[6*32 +: 32] !== ~old_v) begin n_fail++;
      $display("FAIL same_edge_write: got bvalid=%b word6=%h expected 1/%h", s_axil_bvalid, reg_out[6*32 +: 32], ~old_v); end
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    tick();
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    n_checks++; if (s_axil_bvalid !== 1'b0 || s_axil_rvalid !== 1'b0) begin n_fail++;
      $display("FAIL same_edge_close: got bvalid=%b rvalid=%b expected 0/0", s_axil_bvalid, s_axil_rvalid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; bit to; int cnt;
    s_axil_awaddr = 12'h01C; s_axil_awvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    model_clear();
    n_checks++; if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid} !== 5'b0) begin n_fail++;
      $display("FAIL midrst_ctrl: got %b expected 00000", {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid}); end
    n_checks++; if (reg_out !== 512'b0 || wr_pulse !== 16'h0 || s_axil_rdata !== 32'h0) begin n_fail++;
      $display("FAIL midrst_data: got pulse=%h rdata=%h (reg_out nonzero=%b) expected 0", wr_pulse, s_axil_rdata, |reg_out); end
    tick(); tick();
    aresetn = 1'b1;
    tick();
    s_axil_wdata = 32'hFEEDC0DE; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    n_checks++; if (s_axil_wready !== 1'b1) begin n_fail++;
      $display("FAIL midrst_wready: got %b expected 1", s_axil_wready); end
    tick();
    s_axil_wvalid = 1'b0;
    repeat (5) begin
      tick();
      n_checks++; if (s_axil_bvalid !== 1'b0) begin n_fail++;
        $display("FAIL midrst_w_alone: got bvalid=%b expected 0", s_axil_bvalid); end
    end
    s_axil_awaddr = 12'h01C; s_axil_awvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0;
    cnt = 0;
    while (!s_axil_bvalid && cnt < 20) begin tick(); cnt++; end
    model_write(12'h01C, 32'hFEEDC0DE, 4'hF);
    n_checks++; if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== 2'b00 || wr_pulse !== 16'h0080) begin n_fail++;
      $display("FAIL midrst_commit: got bvalid=%b bresp=%b pulse=%h expected 1/00/0080", s_axil_bvalid, s_axil_bresp, wr_pulse); end
    s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0;
    axi_read(12'h01C, d, r, to);
    n_checks++; if (to !== 1'b0 || d !== 32'hFEEDC0DE || r !== 2'b00 || reg_out !== model_flat()) begin n_fail++;
      $display("FAIL midrst_readback: got to=%b rdata=%h rresp=%b expected 0/feedc0de/00", to, d, r); end
  endtask

  task automatic test_random();
    logic [11:0] a; logic [31:0] data, d; logic [3:0] s; logic [1:0] r; logic [15:0] p, ep; bit to;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) a = 12'($urandom_range(64, 4095));
      else a = 12'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        s = 4'($urandom_range(0, 15));
        ep = in_range(a) ? (16'h1 << (a / 4)) : 16'h0;
        axi_write(a, data, s, r, p, to);
        model_write(a, data, s);
        n_checks++; if (to !== 1'b0 || r !== exp_resp(a) || p !== ep || reg_out !== model_flat()) begin n_fail++;
          $display("FAIL rand_write[%0d] addr=%h: got to=%b bresp=%b pulse=%h expected 0/%b/%h (reg_out match=%b)",
                   i, a, to, r, p, exp_resp(a), ep, reg_out === model_flat()); end
      end else begin
        axi_read(a, d, r, to);
        n_checks++; if (to !== 1'b0 || r !== exp_resp(a) || d !== (in_range(a) ? model[a / 4] : 32'h0)) begin n_fail++;
          $display("FAIL rand_read[%0d] addr=%h: got to=%b rdata=%h rresp=%b expected 0/%h/%b",
                   i, a, to, d, r, in_range(a) ? model[a / 4] : 32'h0, exp_resp(a)); end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_w_before_aw();
    test_out_of_range();
    test_bready_stall();
    test_read_stall();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
